// File: rtl/mips_mem_arbiter.sv
`timescale 1ns/1ps
// Single-port arbiter for the unified MIPS32 memory: loader, data stage and fetch
// share one port, gated by a BOOT/RUN/HALTED sequencer.
module mips_mem_arbiter #(
  parameter int unsigned AW              = 10,
  parameter int unsigned DW              = 32,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          boot_done,
  input  logic          cpu_halted,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    state,
  output logic          fetch_stall,
  output logic          data_stall
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_LD   = 2'b01,
    TAG_IF   = 2'b10,
    TAG_DM   = 2'b11
  } tag_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  tag_e            tag_q, tag_d;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      streak_q <= '0;
      tag_q    <= TAG_NONE;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      tag_q    <= tag_d;
    end
  end

  // Sequencer: boot -> run -> halted -> boot (reload)
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT:   if (boot_done)  state_d = ST_RUN;
      ST_RUN:    if (cpu_halted) state_d = ST_HALTED;
      ST_HALTED: if (boot_done)  state_d = ST_BOOT;
      default:                   state_d = ST_BOOT;
    endcase
  end

  // Grants are withheld while reset is asserted so no strobe escapes mid-reset.
  always_comb begin
    ld_gnt = 1'b0;
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == ST_RUN) begin
        if (if_req && (!dm_req || streak_q == STREAK_MAX)) begin
          if_gnt = 1'b1;
        end else if (dm_req) begin
          dm_gnt = 1'b1;
        end
      end else begin
        ld_gnt = ld_req;
      end
    end
  end

  // Memory port mux, read tag and starvation-guard counter
  always_comb begin
    mem_en    = ld_gnt | if_gnt | dm_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = TAG_NONE;
    streak_d  = streak_q;
    if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      tag_d     = ld_we ? TAG_NONE : TAG_LD;
    end else if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      tag_d     = dm_we ? TAG_NONE : TAG_DM;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
      tag_d     = TAG_IF;
    end
    if (!if_req || if_gnt) begin
      streak_d = '0;
    end else if (dm_gnt && streak_q < STREAK_MAX) begin
      streak_d = streak_q + SW'(1);
    end
  end

  assign ld_rvalid   = (tag_q == TAG_LD);
  assign if_rvalid   = (tag_q == TAG_IF);
  assign dm_rvalid   = (tag_q == TAG_DM);
  assign rdata       = mem_rdata;
  assign state       = state_q;
  assign fetch_stall = if_req & ~if_gnt;
  assign data_stall  = dm_req & ~dm_gnt;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mips_mem_arbiter: a memory array behind the port, a rule-level
// reference model checked every cycle, and literal pins for the headline scenarios.
module tb_mips_mem_arbiter;

  localparam int MAXS = 4;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        boot_done = 1'b0, cpu_halted = 1'b0;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_wdata = '0;
  logic        if_req = 1'b0;
  logic [9:0]  if_addr = '0;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [9:0]  dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] mem_rdata = '0;
  logic        ld_gnt, ld_rvalid, if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] rdata, mem_wdata;
  logic        mem_en, mem_we, fetch_stall, data_stall;
  logic [9:0]  mem_addr;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  mips_mem_arbiter #(.AW(10), .DW(32), .MAX_DATA_STREAK(MAXS)) dut (
    .clk1(clk1), .rst_n(rst_n), .boot_done(boot_done), .cpu_halted(cpu_halted),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state(state), .fetch_stall(fetch_stall), .data_stall(data_stall)
  );

  always #5 clk1 = ~clk1;

  // Memory array behind the port: synchronous write, 1-cycle read latency
  bit [31:0] mem_arr [1024];
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 BOOT, 1 RUN, 2 HALTED; pend 0 none, 1 LD, 2 IF, 3 DM
  int        m_state = 0, m_streak = 0, m_pend = 0;
  bit [31:0] m_pdata = 0;
  int        n_state = 0, n_streak = 0, n_pend = 0;
  bit [31:0] n_pdata = 0;
  bit [31:0] ref_mem [1024];

  always @(negedge clk1) begin : model
    logic eld, eif, edm, ewe;
    int   eaddr;
    if (!rst_n) begin
      chk("rst_gnt", {ld_gnt, if_gnt, dm_gnt, mem_en}, 0);
      chk("rst_rvalid", {ld_rvalid, if_rvalid, dm_rvalid}, 0);
      chk("rst_state", state, 0);
      n_state <= 0; n_streak <= 0; n_pend <= 0; n_pdata <= 0;
    end else begin
      eld = (m_state != 1) && ld_req;
      eif = (m_state == 1) && if_req && (!dm_req || m_streak == MAXS);
      edm = (m_state == 1) && dm_req && !eif;
      ewe = eld ? ld_we : (edm ? dm_we : 1'b0);
      eaddr = eld ? int'(ld_addr) : (edm ? int'(dm_addr) : int'(if_addr));
      chk("gnt", {ld_gnt, if_gnt, dm_gnt}, {29'd0, eld, eif, edm});
      chk("mem_en", mem_en, eld | eif | edm);
      if (eld | eif | edm) begin
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, eaddr);
        if (ewe) begin
          chk("mem_wdata", mem_wdata, eld ? ld_wdata : dm_wdata);
          ref_mem[eaddr] <= eld ? ld_wdata : dm_wdata;
        end
      end
      chk("state", state, m_state);
      chk("stalls", {fetch_stall, data_stall}, {30'd0, if_req && !eif, dm_req && !edm});
      chk("rvalid", {ld_rvalid, if_rvalid, dm_rvalid},
          {29'd0, m_pend == 1, m_pend == 2, m_pend == 3});
      if (m_pend != 0) chk("rdata", rdata, m_pdata);
      // next-cycle model state
      if (m_state == 0 && boot_done)       n_state <= 1;
      else if (m_state == 1 && cpu_halted) n_state <= 2;
      else if (m_state == 2 && boot_done)  n_state <= 0;
      else                                 n_state <= m_state;
      if (!if_req || eif)  n_streak <= 0;
      else if (edm)        n_streak <= (m_streak < MAXS) ? m_streak + 1 : MAXS;
      else                 n_streak <= m_streak;
      n_pend  <= (eld && !ld_we) ? 1 : (eif ? 2 : ((edm && !dm_we) ? 3 : 0));
      n_pdata <= ref_mem[eaddr];
    end
  end

  always @(posedge clk1) begin
    if (!rst_n) begin
      m_state <= 0; m_streak <= 0; m_pend <= 0; m_pdata <= 0;
    end else begin
      m_state <= n_state; m_streak <= n_streak; m_pend <= n_pend; m_pdata <= n_pdata;
    end
  end

  task automatic cyc();
    @(posedge clk1); #1;
  endtask

  task automatic ld_op(input logic we, input int addr, input logic [31:0] d);
    cyc();
    ld_req = 1'b1; ld_we = we; ld_addr = 10'(addr); ld_wdata = d;
    #1 chk("ld_mem_we", mem_we, we);
    cyc();
    ld_req = 1'b0; ld_we = 1'b0;
  endtask

  task automatic pulse_boot();
    cyc(); boot_done = 1'b1;
    cyc(); boot_done = 1'b0;
  endtask

  task automatic pulse_halt();
    cyc(); cpu_halted = 1'b1;
    cyc(); cpu_halted = 1'b0;
  endtask

  logic [9:0] got_pat;
  logic [9:0] exp_pat;

  initial begin
    // 1: reset
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    chk("t1_state", state, 2'b00);
    chk("t1_outputs", {mem_en, mem_we, ld_gnt, if_gnt, dm_gnt, fetch_stall, data_stall}, 0);
    if_req = 1'b1;
    #1 chk("t1_fetch_stall", fetch_stall, 1'b1);
    chk("t1_if_gnt", if_gnt, 1'b0);
    cyc(); rst_n = 1'b1;
    cyc(); if_req = 1'b0;

    // 2: boot load
    ld_op(1'b1, 0, 32'h2801_0078);
    ld_op(1'b1, 120, 32'd85);
    ld_op(1'b0, 120, 32'd0);
    chk("t2_ld_rvalid", ld_rvalid, 1'b1);
    chk("t2_rdata", rdata, 32'd85);
    pulse_boot();
    chk("t2_state_run", state, 2'b01);

    // 3: DM vs IF contention, starvation guard
    exp_pat = 10'h210;
    cyc();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120; if_req = 1'b1; if_addr = 10'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      got_pat[i] = if_gnt;
      chk("t3_data_stall", data_stall, exp_pat[i]);
    end
    cyc();
    dm_req = 1'b0; if_req = 1'b0;
    chk("t3_pattern", got_pat, exp_pat);

    // 4: pipelined fetch 0..3
    cyc();
    if_req = 1'b1; if_addr = 10'd0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k < 3) if_addr = 10'(k + 1);
      else       if_req = 1'b0;
      chk("t4_if_rvalid", if_rvalid, 1'b1);
      if (k == 0) chk("t4_rdata0", rdata, 32'h2801_0078);
    end
    cyc();
    chk("t4_if_rvalid_end", if_rvalid, 1'b0);

    // 5: store then halt, post-halt readout
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd121; dm_wdata = 32'd85;
    cyc();
    dm_req = 1'b0; dm_we = 1'b0;
    pulse_halt();
    chk("t5_state_halted", state, 2'b10);
    if_req = 1'b1;
    #1 chk("t5_fetch_stall", fetch_stall, 1'b1);
    ld_op(1'b0, 121, 32'd0);
    chk("t5_ld_rvalid", ld_rvalid, 1'b1);
    chk("t5_rdata", rdata, 32'd85);
    if_req = 1'b0;

    // 6: reset during a granted DM read
    pulse_boot();
    chk("t6_state_boot", state, 2'b00);
    pulse_boot();
    chk("t6_state_run", state, 2'b01);
    cyc();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120;
    @(negedge clk1);
    chk("t6_dm_gnt", dm_gnt, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("t6_state_rst", state, 2'b00);
    chk("t6_no_strobe", mem_en, 1'b0);
    cyc();
    chk("t6_dm_rvalid", dm_rvalid, 1'b0);
    dm_req = 1'b0; rst_n = 1'b1;
    repeat (3) cyc();
    chk("t6_state_after", state, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
